// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, geometry helpers and byte merge for the direct-mapped data cache
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WRITE  = 2'd2
  } state_e;

  localparam int ADDR_W = 32;
  localparam int OFF_W  = 2;

  function automatic int word_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines, input int line_words);
    return ADDR_W - OFF_W - word_w(line_words) - idx_w(lines);
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dcache_store.sv
// rtl/dcache_store.sv - valid/tag/data arrays with async read and one byte-enabled write port
module dcache_store
  import dcache_pkg::*;
#(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4,
  localparam int IDX_W  = idx_w(LINES),
  localparam int WORD_W = word_w(LINE_WORDS),
  localparam int TAG_W  = tag_w(LINES, LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_index,
  input  logic [WORD_W-1:0] rd_word,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [31:0]       rd_data,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [WORD_W-1:0] wr_word,
  input  logic              wr_en,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_be,
  input  logic              inv_en,
  input  logic              set_en,
  input  logic [TAG_W-1:0]  set_tag
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][LINE_WORDS];

  always_comb begin
    valid_d = valid_q;
    if (inv_en) valid_d[wr_index] = 1'b0;
    if (set_en) valid_d[wr_index] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data contents are meaningless until the valid bit is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (set_en) begin
      tag_q[wr_index] <= set_tag;
    end
    if (wr_en) begin
      data_q[wr_index][wr_word] <= byte_merge(data_q[wr_index][wr_word], wr_data, wr_be);
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index][rd_word];

endmodule

// File: rtl/dcache_direct.sv
// rtl/dcache_direct.sv - direct-mapped write-through no-write-allocate data cache for the memory stage
module dcache_direct
  import dcache_pkg::*;
#(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ReqM,
  input  logic        WeM,
  input  logic [31:0] AddrM,
  input  logic [31:0] WDataM,
  input  logic [3:0]  ByteEnM,
  output logic [31:0] RDataM,
  output logic        StallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int IDX_W   = idx_w(LINES);
  localparam int WORD_W  = word_w(LINE_WORDS);
  localparam int TAG_W   = tag_w(LINES, LINE_WORDS);
  localparam int IDX_LSB = OFF_W + WORD_W;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic [29:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;

  logic [WORD_W-1:0] req_word;
  logic [IDX_W-1:0]  req_index;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  lat_index;
  logic [TAG_W-1:0]  lat_tag;
  logic              unused_addr_lo;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_data;
  logic              hit;

  logic [IDX_W-1:0]  wr_index;
  logic [WORD_W-1:0] wr_word;
  logic              wr_en;
  logic [31:0]       wr_data;
  logic [3:0]        wr_be;
  logic              inv_en;
  logic              set_en;
  logic              stall_c;
  logic [31:0]       rdata_c;

  assign req_word       = AddrM[OFF_W +: WORD_W];
  assign req_index      = AddrM[IDX_LSB +: IDX_W];
  assign req_tag        = AddrM[31 -: TAG_W];
  assign lat_index      = addr_q[IDX_LSB-OFF_W +: IDX_W];
  assign lat_tag        = addr_q[29 -: TAG_W];
  assign unused_addr_lo = ^AddrM[1:0];

  dcache_store #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_store (
    .clk      (clk),
    .rst_n    (rst),
    .rd_index (req_index),
    .rd_word  (req_word),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_index (wr_index),
    .wr_word  (wr_word),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .inv_en   (inv_en),
    .set_en   (set_en),
    .set_tag  (lat_tag)
  );

  assign hit = rd_valid && (rd_tag == req_tag);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      ST_IDLE: begin
        if (ReqM) begin
          if (WeM) begin
            addr_d  = AddrM[31:2];
            wdata_d = WDataM;
            be_d    = ByteEnM;
            state_d = ST_WRITE;
          end else if (!hit) begin
            addr_d  = AddrM[31:2];
            cnt_d   = '0;
            state_d = ST_REFILL;
          end
        end
      end
      ST_REFILL: begin
        if (mem_ack) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_WORD) state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (mem_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Store hits merge into the array at the IDLE edge; refill words land in the latched line.
  always_comb begin
    stall_c   = 1'b0;
    rdata_c   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    wr_index  = req_index;
    wr_word   = req_word;
    wr_en     = 1'b0;
    wr_data   = WDataM;
    wr_be     = ByteEnM;
    inv_en    = 1'b0;
    set_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ReqM) begin
          if (WeM) begin
            stall_c = 1'b1;
            wr_en   = hit;
          end else if (hit) begin
            rdata_c = rd_data;
          end else begin
            stall_c = 1'b1;
            inv_en  = 1'b1;
          end
        end
      end
      ST_REFILL: begin
        stall_c  = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {lat_tag, lat_index, cnt_q, 2'b00};
        wr_index = lat_index;
        wr_word  = cnt_q;
        wr_data  = mem_rdata;
        wr_be    = 4'hF;
        wr_en    = mem_ack;
        set_en   = mem_ack && (cnt_q == LAST_WORD);
      end
      ST_WRITE: begin
        stall_c   = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr_q, 2'b00};
        mem_wdata = wdata_q;
        mem_be    = be_q;
      end
      default: begin
        stall_c = 1'b0;
      end
    endcase
  end

  // Reset must silence the pipeline-facing outputs even while ReqM is still asserted.
  assign StallM = stall_c & rst;
  assign RDataM = rst ? rdata_c : '0;

endmodule

// File: tb/tb_dcache_direct.sv
// tb/tb_dcache_direct.sv - directed table-driven bench for dcache_direct with a word-wide memory model
module tb_dcache_direct;

  logic        clk = 1'b0;
  logic        rst;
  logic        ReqM;
  logic        WeM;
  logic [31:0] AddrM;
  logic [31:0] WDataM;
  logic [3:0]  ByteEnM;
  logic [31:0] RDataM;
  logic        StallM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  dcache_direct dut (
    .clk       (clk),
    .rst       (rst),
    .ReqM      (ReqM),
    .WeM       (WeM),
    .AddrM     (AddrM),
    .WDataM    (WDataM),
    .ByteEnM   (ByteEnM),
    .RDataM    (RDataM),
    .StallM    (StallM),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          waits;
    logic [31:0] exp_rdata;
    int          exp_cycles;
    int          exp_reads;
    int          exp_writes;
  } vec_t;

  logic [31:0] bmem [0:1023];
  logic [31:0] txn_addr  [$];
  logic        txn_we    [$];
  logic [31:0] txn_wdata [$];
  logic [3:0]  txn_be    [$];

  int passed = 0;
  int total  = 0;
  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Drives one pipeline access and plays the backing memory with a fixed wait count per beat.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int waits,
                        output int cycles, output logic [31:0] rdata);
    int          wcnt = 0;
    int          guard = 0;
    bit          done = 0;
    bit          acked;
    logic [31:0] first_addr = '0;
    txn_addr.delete();
    txn_we.delete();
    txn_wdata.delete();
    txn_be.delete();
    cycles = 0;
    rdata  = '0;
    @(negedge clk);
    ReqM = 1'b1; WeM = we; AddrM = addr; WDataM = wdata; ByteEnM = be;
    mem_ack = 1'b0; mem_rdata = 32'hBAD0BAD0;
    while (!done && guard < 300) begin
      #1;
      if (!StallM) begin
        rdata = RDataM;
        done  = 1;
      end else begin
        cycles++;
        acked = 0;
        if (mem_req) begin
          if (wcnt == 0) first_addr = mem_addr;
          if (wcnt == waits) begin
            chk("addr_stable", mem_addr, first_addr);
            txn_addr.push_back(mem_addr);
            txn_we.push_back(mem_we);
            txn_wdata.push_back(mem_wdata);
            txn_be.push_back(mem_be);
            if (mem_we) begin
              for (int b = 0; b < 4; b++)
                if (mem_be[b]) bmem[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            end else begin
              mem_rdata = bmem[mem_addr[11:2]];
            end
            mem_ack = 1'b1;
            acked   = 1;
            wcnt    = 0;
          end else begin
            wcnt++;
          end
        end
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'hBAD0BAD0;
        if (we && acked) begin
          ReqM = 1'b0;
          done = 1;
        end
        guard++;
      end
    end
    if (!done) begin
      chk("access_timeout", 32'd0, 32'd1);
      ReqM = 1'b0;
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int          cycles;
    int          nreads = 0;
    int          nwrites = 0;
    logic [31:0] rdata;
    access(v.we, v.addr, v.wdata, v.be, v.waits, cycles, rdata);
    for (int k = 0; k < txn_we.size(); k++) begin
      if (txn_we[k]) nwrites++;
      else nreads++;
    end
    if (!v.we) chk($sformatf("v%0d_rdata", id), rdata, v.exp_rdata);
    chk($sformatf("v%0d_cycles", id), cycles, v.exp_cycles);
    chk($sformatf("v%0d_reads", id), nreads, v.exp_reads);
    chk($sformatf("v%0d_writes", id), nwrites, v.exp_writes);
    if (v.exp_reads == 4 && txn_addr.size() == 4) begin
      for (int k = 0; k < 4; k++)
        chk($sformatf("v%0d_raddr%0d", id, k), txn_addr[k], (v.addr & 32'hFFFF_FFF0) + 32'(4 * k));
    end
    if (v.exp_writes == 1 && txn_addr.size() == 1) begin
      chk($sformatf("v%0d_waddr", id), txn_addr[0], v.addr & 32'hFFFF_FFFC);
      chk($sformatf("v%0d_wdata", id), txn_wdata[0], v.wdata);
      chk($sformatf("v%0d_wbe", id), {28'd0, txn_be[0]}, {28'd0, v.be});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          acks;
    int          guard;
    vec_t        v;

    for (int i = 0; i < 1024; i++) bmem[i] = 32'h0;
    for (int k = 0; k < 4; k++) begin
      bmem[32'h40 + k] = {4{8'hA0 + 8'(k)}};
      bmem[32'h80 + k] = {4{8'hB0 + 8'(k)}};
      bmem[32'hC0 + k] = {4{8'hC0 + 8'(k)}};
      bmem[32'h54 + k] = 32'h5500_0000 + 32'(k);
    end

    vecs[0]  = '{1'b0, 32'h100, 32'h0,        4'h0, 1, 32'hA0A0A0A0,  9, 4, 0};
    vecs[1]  = '{1'b0, 32'h108, 32'h0,        4'h0, 0, 32'hA2A2A2A2,  0, 0, 0};
    vecs[2]  = '{1'b1, 32'h104, 32'hDEADBEEF, 4'h3, 1, 32'h0,         3, 0, 1};
    vecs[3]  = '{1'b0, 32'h104, 32'h0,        4'h0, 0, 32'hA1A1BEEF,  0, 0, 0};
    vecs[4]  = '{1'b0, 32'h200, 32'h0,        4'h0, 0, 32'hB0B0B0B0,  5, 4, 0};
    vecs[5]  = '{1'b0, 32'h100, 32'h0,        4'h0, 0, 32'hA0A0A0A0,  5, 4, 0};
    vecs[6]  = '{1'b0, 32'h20C, 32'h0,        4'h0, 0, 32'hB3B3B3B3,  5, 4, 0};
    vecs[7]  = '{1'b1, 32'h300, 32'h11223344, 4'hF, 2, 32'h0,         4, 0, 1};
    vecs[8]  = '{1'b0, 32'h300, 32'h0,        4'h0, 0, 32'h11223344,  5, 4, 0};
    vecs[9]  = '{1'b0, 32'h304, 32'h0,        4'h0, 0, 32'hC1C1C1C1,  0, 0, 0};
    vecs[10] = '{1'b1, 32'h308, 32'hAABBCCDD, 4'hC, 0, 32'h0,         2, 0, 1};
    vecs[11] = '{1'b0, 32'h308, 32'h0,        4'h0, 0, 32'hAABBC2C2,  0, 0, 0};
    vecs[12] = '{1'b0, 32'h10C, 32'h0,        4'h0, 2, 32'hA3A3A3A3, 13, 4, 0};
    vecs[13] = '{1'b0, 32'h150, 32'h0,        4'h0, 0, 32'h55000000,  5, 4, 0};
    vecs[14] = '{1'b0, 32'h108, 32'h0,        4'h0, 0, 32'hA2A2A2A2,  0, 0, 0};
    vecs[15] = '{1'b0, 32'h104, 32'h0,        4'h0, 0, 32'hA1A1BEEF,  0, 0, 0};

    rst = 1'b0; ReqM = 1'b0; WeM = 1'b0; AddrM = '0; WDataM = '0; ByteEnM = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_stall", {31'd0, StallM}, 32'd0);
    chk("rst_rdata", RDataM, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

    // Stray acks with no request outstanding must not disturb anything.
    @(negedge clk);
    ReqM = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    #1;
    chk("stray_ack_req", {31'd0, mem_req}, 32'd0);
    chk("stray_ack_stall", {31'd0, StallM}, 32'd0);
    mem_ack = 1'b0;
    v = '{1'b0, 32'h108, 32'h0, 4'h0, 0, 32'hA2A2A2A2, 0, 0, 0};
    run_vec(20, v);

    // Evict index 0, then abandon a refill of 0x100 halfway with reset.
    v = '{1'b0, 32'h300, 32'h0, 4'h0, 0, 32'h11223344, 5, 4, 0};
    run_vec(21, v);
    @(negedge clk);
    ReqM = 1'b1; WeM = 1'b0; AddrM = 32'h100;
    acks = 0; guard = 0;
    while (acks < 2 && guard < 50) begin
      #1;
      if (mem_req) begin
        mem_ack = 1'b1;
        mem_rdata = bmem[mem_addr[11:2]];
        acks++;
      end
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = 32'hBAD0BAD0;
      guard++;
    end
    #1;
    chk("midrefill_req", {31'd0, mem_req}, 32'd1);
    chk("midrefill_addr", mem_addr, 32'h108);
    rst = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, mem_req}, 32'd0);
    chk("async_rst_stall", {31'd0, StallM}, 32'd0);
    chk("async_rst_rdata", RDataM, 32'd0);
    chk("async_rst_addr", mem_addr, 32'd0);
    @(negedge clk);
    ReqM = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    v = '{1'b0, 32'h100, 32'h0, 4'h0, 0, 32'hA0A0A0A0, 5, 4, 0};
    run_vec(22, v);
    v = '{1'b0, 32'h304, 32'h0, 4'h0, 0, 32'hC1C1C1C1, 5, 4, 0};
    run_vec(23, v);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
